// File: rtl/ula_arbiter.sv
// ula_arbiter: shares one combinational ula between two requesters.
// Each requester hands over op/a/b on a valid/ready handshake. The winner's
// operands are captured, the ula result is registered, and the result is
// returned on that requester's response channel. Responses support
// backpressure, and only one operation is in flight at a time.
//
// Arbitration is round-robin by default. Define ULA_ARB_FIXED_PRIO_EN to give
// req0 fixed priority instead; in that mode req1 can starve.
//
// ula opcode map: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 not a,
// 6 shift left, 7 logical shift right. Any other opcode yields 0.
// A shift amount >= BITS yields 0.
module ula_arbiter #(
  parameter int BITS = 8,
  parameter int OP   = 8
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            req0_valid_in,
  output logic            req0_ready_out,
  input  logic [OP-1:0]   req0_op_in,
  input  logic [BITS-1:0] req0_a_in,
  input  logic [BITS-1:0] req0_b_in,
  output logic            rsp0_valid_out,
  input  logic            rsp0_ready_in,
  output logic [BITS-1:0] rsp0_result_out,
  input  logic            req1_valid_in,
  output logic            req1_ready_out,
  input  logic [OP-1:0]   req1_op_in,
  input  logic [BITS-1:0] req1_a_in,
  input  logic [BITS-1:0] req1_b_in,
  output logic            rsp1_valid_out,
  input  logic            rsp1_ready_in,
  output logic [BITS-1:0] rsp1_result_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [OP-1:0]   op_q, op_d;
  logic [BITS-1:0] a_q, a_d;
  logic [BITS-1:0] b_q, b_d;
  logic            id_q, id_d;
  logic [BITS-1:0] result_q, result_d;
`ifndef ULA_ARB_FIXED_PRIO_EN
  logic            last_q, last_d;
`endif

  logic grantValid;
  logic grantId;
  logic rspReady;

  // The shared ula: pure combinational function of the captured operands.
  // SystemVerilog shifts by an amount >= the operand width already give 0.
  function automatic logic [BITS-1:0] ulaEval(
    input logic [OP-1:0]   op,
    input logic [BITS-1:0] a,
    input logic [BITS-1:0] b
  );
    logic [BITS-1:0] r;
    case (op)
      OP'(0):  r = a + b;
      OP'(1):  r = a - b;
      OP'(2):  r = a & b;
      OP'(3):  r = a | b;
      OP'(4):  r = a ^ b;
      OP'(5):  r = ~a;
      OP'(6):  r = a << b;
      OP'(7):  r = a >> b;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Pick a winner among the valid requesters. A tie goes to whoever was not
  // served last, or always to req0 when fixed priority is enabled.
  always_comb begin
    grantValid = req0_valid_in | req1_valid_in;
`ifdef ULA_ARB_FIXED_PRIO_EN
    grantId = ~req0_valid_in;
`else
    if (req0_valid_in && req1_valid_in) begin
      grantId = ~last_q;
    end else begin
      grantId = ~req0_valid_in;
    end
`endif
  end

  // Next-state and output logic. While reset is high every output is held
  // at 0, so no handshake can complete in a reset cycle.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    id_d     = id_q;
    result_d = result_q;
`ifndef ULA_ARB_FIXED_PRIO_EN
    last_d   = last_q;
`endif
    req0_ready_out  = 1'b0;
    req1_ready_out  = 1'b0;
    rsp0_valid_out  = 1'b0;
    rsp1_valid_out  = 1'b0;
    rsp0_result_out = '0;
    rsp1_result_out = '0;
    rspReady = id_q ? rsp1_ready_in : rsp0_ready_in;

    case (state_q)
      IDLE: begin
        req0_ready_out = ~rst_in & grantValid & ~grantId;
        req1_ready_out = ~rst_in & grantValid & grantId;
        if (grantValid) begin
          state_d = EXEC;
          id_d    = grantId;
          op_d    = grantId ? req1_op_in : req0_op_in;
          a_d     = grantId ? req1_a_in  : req0_a_in;
          b_d     = grantId ? req1_b_in  : req0_b_in;
        end
      end
      EXEC: begin
        result_d = ulaEval(op_q, a_q, b_q);
        state_d  = RESP;
      end
      RESP: begin
        rsp0_valid_out  = ~rst_in & ~id_q;
        rsp1_valid_out  = ~rst_in & id_q;
        rsp0_result_out = rsp0_valid_out ? result_q : '0;
        rsp1_result_out = rsp1_valid_out ? result_q : '0;
        if (rspReady) begin
          state_d = IDLE;
`ifndef ULA_ARB_FIXED_PRIO_EN
          last_d  = id_q;
`endif
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset drops any in-flight operation.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      id_q     <= 1'b0;
      result_q <= '0;
`ifndef ULA_ARB_FIXED_PRIO_EN
      last_q   <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      id_q     <= id_d;
      result_q <= result_d;
`ifndef ULA_ARB_FIXED_PRIO_EN
      last_q   <= last_d;
`endif
    end
  end

endmodule
